// File: rtl/scmi_reg_arbiter.sv
// rtl/scmi_reg_arbiter.sv - round-robin arbiter sharing the SCMI mailbox reg bus between requesters
// Adds one registered arbitration cycle per transaction; lock keeps the grant across RMW sequences.
module scmi_reg_arbiter #(
  parameter int NumReq    = 2,
  parameter int AddrWidth = 64,
  parameter int DataWidth = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumReq-1:0]               req_valid_i,
  input  logic [NumReq-1:0]               req_write_i,
  input  logic [NumReq-1:0]               req_lock_i,
  input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
  input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
  input  logic [NumReq*DataWidth/8-1:0]   req_wstrb_i,
  output logic [NumReq-1:0]               req_ready_o,
  output logic [DataWidth-1:0]            req_rdata_o,
  output logic                            req_error_o,
  output logic                            reg_valid_o,
  output logic                            reg_write_o,
  output logic [AddrWidth-1:0]            reg_addr_o,
  output logic [DataWidth-1:0]            reg_wdata_o,
  output logic [DataWidth/8-1:0]          reg_wstrb_o,
  input  logic                            reg_ready_i,
  input  logic [DataWidth-1:0]            reg_rdata_i,
  input  logic                            reg_error_i,
  output logic [$clog2(NumReq)-1:0]       grant_o,
  output logic                            busy_o
);

  localparam int IdxW = $clog2(NumReq);
  localparam int StrbWidth = DataWidth / 8;
  localparam int unsigned NumReqU = NumReq;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic            locked_q, locked_d;
  logic            pick_found;
  logic [IdxW-1:0] pick_idx;
  logic            busy;
  logic            gnt_valid;

  // Index arithmetic modulo NumReq so non-power-of-2 requester counts wrap correctly.
  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NumReqU) s = s - NumReqU;
    return s[IdxW-1:0];
  endfunction

  assign busy      = (state_q == BUSY);
  assign gnt_valid = req_valid_i[grant_q];

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NumReqU; i++) begin
      if (!pick_found && req_valid_i[wrap_add(ptr_q, i)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(ptr_q, i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    locked_d = locked_q;
    case (state_q)
      IDLE: begin
        if (locked_q) begin
          // Locked owner either starts its next txn or releases the lock by idling.
          if (gnt_valid) state_d = BUSY;
          else if (!req_lock_i[grant_q]) locked_d = 1'b0;
        end else if (pick_found) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!gnt_valid) begin
          state_d  = IDLE;
          locked_d = 1'b0;
          ptr_d    = wrap_add(grant_q, 1);
        end else if (reg_ready_i) begin
          state_d  = IDLE;
          locked_d = req_lock_i[grant_q];
          if (!req_lock_i[grant_q]) ptr_d = wrap_add(grant_q, 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign reg_valid_o = busy & gnt_valid;
  assign reg_write_o = busy & req_write_i[grant_q];
  assign reg_addr_o  = busy ? req_addr_i[int'(grant_q)*AddrWidth +: AddrWidth] : '0;
  assign reg_wdata_o = busy ? req_wdata_i[int'(grant_q)*DataWidth +: DataWidth] : '0;
  assign reg_wstrb_o = busy ? req_wstrb_i[int'(grant_q)*StrbWidth +: StrbWidth] : '0;

  always_comb begin
    req_ready_o = '0;
    if (busy && gnt_valid && reg_ready_i) req_ready_o[grant_q] = 1'b1;
  end

  assign req_rdata_o = busy ? reg_rdata_i : '0;
  assign req_error_o = busy & reg_error_i;
  assign grant_o     = grant_q;
  assign busy_o      = busy;

endmodule
